// File: rtl/color_fsm_pkg.sv
// color_fsm_pkg: shared types and helpers for the colour sequencer.
//   color_state_t : 2-bit state encoding (Blue/Red/Green, 2'h3 unreachable)
//   color_cmd_t   : command opcode carried on in[1:0]
//   OUT_*         : per-state output codes
//   next_color()  : target state for a (state, command) pair, ignoring the dwell gate
//   color_code()  : output code for a state
package color_fsm_pkg;

  typedef enum logic [1:0] {
    ST_BLUE  = 2'h0,
    ST_RED   = 2'h1,
    ST_GREEN = 2'h2,
    ST_BAD   = 2'h3
  } color_state_t;

  typedef enum logic [1:0] {
    CMD_HOLD    = 2'h0,
    CMD_ADVANCE = 2'h1,
    CMD_REVERSE = 2'h2,
    CMD_HOME    = 2'h3
  } color_cmd_t;

  localparam logic [1:0] OUT_BLUE  = 2'd1;
  localparam logic [1:0] OUT_RED   = 2'd2;
  localparam logic [1:0] OUT_GREEN = 2'd3;
  localparam logic [1:0] OUT_BAD   = 2'd0;

  // Advance walks Red->Green->Blue->Red, reverse walks the ring the other way.
  // The unreachable encoding always heads back to Red.
  function automatic color_state_t next_color(color_state_t s, color_cmd_t c);
    color_state_t n;
    n = s;
    if (s == ST_BAD) begin
      n = ST_RED;
    end else begin
      case (c)
        CMD_ADVANCE: begin
          case (s)
            ST_RED:   n = ST_GREEN;
            ST_GREEN: n = ST_BLUE;
            default:  n = ST_RED;
          endcase
        end
        CMD_REVERSE: begin
          case (s)
            ST_RED:  n = ST_BLUE;
            ST_BLUE: n = ST_GREEN;
            default: n = ST_RED;
          endcase
        end
        CMD_HOME: n = ST_RED;
        default:  n = s;
      endcase
    end
    return n;
  endfunction

  function automatic logic [1:0] color_code(color_state_t s);
    logic [1:0] o;
    case (s)
      ST_BLUE:  o = OUT_BLUE;
      ST_RED:   o = OUT_RED;
      ST_GREEN: o = OUT_GREEN;
      default:  o = OUT_BAD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/color_seq_fsm_if.sv
// color_seq_fsm_if: command/status bundle of the colour sequencer.
//   en, in                      : command side, driven by the master
//   out, state, changed, dwell  : status side, driven by the sequencer (slave)
interface color_seq_fsm_if #(
  parameter int IN_WIDTH    = 2,
  parameter int OUT_WIDTH   = 2,
  parameter int DWELL_WIDTH = 4
);
  logic                   en;
  logic [IN_WIDTH-1:0]    in;
  logic [OUT_WIDTH-1:0]   out;
  logic [1:0]             state;
  logic                   changed;
  logic [DWELL_WIDTH-1:0] dwell;

  modport master (output en, in, input out, state, changed, dwell);
  modport slave  (input en, in, output out, state, changed, dwell);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   clr        : clear to 0 (wins over inc)
//   inc        : increment by one, sticking at all-ones
//   cnt        : current count
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc && cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/color_seq_fsm.sv
// color_seq_fsm: three-state Moore colour sequencer.
//   clk, rst_n : clock, async active-low reset (state Red, dwell 0, changed 0)
//   bus.en     : global enable; low freezes state/dwell and forces changed to 0
//   bus.in     : command, opcode in [1:0]; any set upper bit reads as HOLD
//   bus.out    : state output code, zero-extended
//   bus.state  : current state encoding
//   bus.changed: one-cycle pulse in the first cycle of a new state
//   bus.dwell  : saturating count of cycles spent in the current state
module color_seq_fsm
  import color_fsm_pkg::*;
#(
  parameter int IN_WIDTH    = 2,
  parameter int OUT_WIDTH   = 2,
  parameter int DWELL_WIDTH = 4,
  parameter int MIN_DWELL   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  color_seq_fsm_if.slave    bus
);

  localparam logic [DWELL_WIDTH-1:0] MIN_D = DWELL_WIDTH'(MIN_DWELL);

  color_state_t           state_q, state_d, tgt;
  color_cmd_t             cmd;
  logic                   illegal, gate_ok, xfer, changed_q;
  logic [DWELL_WIDTH-1:0] dwell;

  generate
    if (IN_WIDTH > 2) begin : g_hi
      assign illegal = |bus.in[IN_WIDTH-1:2];
    end else begin : g_nohi
      assign illegal = 1'b0;
    end
  endgenerate

  assign gate_ok = (dwell >= MIN_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RED;
    else        state_q <= state_d;
  end

  // xfer marks an accepted transition: it clears dwell and fires changed.
  // Recovery from the unreachable encoding is unconditional so a corrupted
  // register can't stay stuck while en is low.
  always_comb begin
    state_d = state_q;
    xfer    = 1'b0;
    cmd     = illegal ? CMD_HOLD : color_cmd_t'(bus.in[1:0]);
    tgt     = next_color(state_q, cmd);
    if (state_q == ST_BAD) begin
      xfer    = 1'b1;
      state_d = ST_RED;
    end else if (bus.en) begin
      case (cmd)
        CMD_ADVANCE, CMD_REVERSE: xfer = gate_ok;
        // HOME skips the gate but is a no-op when already Red
        CMD_HOME:                 xfer = (state_q != ST_RED);
        default:                  xfer = 1'b0;
      endcase
      if (xfer) state_d = tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed_q <= 1'b0;
    else        changed_q <= xfer;
  end

  sat_counter #(.WIDTH(DWELL_WIDTH)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (xfer),
    .inc   (bus.en),
    .cnt   (dwell)
  );

  assign bus.state   = state_q;
  assign bus.out     = OUT_WIDTH'(color_code(state_q));
  assign bus.changed = changed_q;
  assign bus.dwell   = dwell;

endmodule

// File: tb/tb_color_seq_fsm.sv
// tb_color_seq_fsm: scoreboard bench for color_seq_fsm (IN_WIDTH=4, MIN_DWELL=2).
// A spec-level model predicts the outputs after each driven cycle; the
// prediction is queued and compared on the following falling edge.
module tb_color_seq_fsm;
  localparam int IW = 4, OW = 2, DW = 4, MD = 2;
  localparam int DMAX = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  color_seq_fsm_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DWELL_WIDTH(DW)) b();

  color_seq_fsm #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DWELL_WIDTH(DW), .MIN_DWELL(MD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  typedef struct packed {
    logic [1:0]    st;
    logic [OW-1:0] o;
    logic [DW-1:0] dw;
    logic          ch;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0, n_err = 0;
  int   m_st, m_dw;   // model state: 0 Blue, 1 Red, 2 Green
  bit   m_ch;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, got, want, $time);
    end
  endtask

  function automatic int code_of(input int s);
    case (s)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 1; m_dw = 0; m_ch = 0;
  endtask

  task automatic model_step(input bit e, input logic [IW-1:0] c);
    int op, tgt;
    bit acc;
    if (!e) begin
      m_ch = 0;
      return;
    end
    op  = (c[IW-1:2] != 0) ? 0 : int'(c[1:0]);
    acc = 0;
    tgt = m_st;
    case (op)
      1: begin tgt = (m_st == 1) ? 2 : (m_st == 2) ? 0 : 1; acc = (m_dw >= MD); end
      2: begin tgt = (m_st == 1) ? 0 : (m_st == 0) ? 2 : 1; acc = (m_dw >= MD); end
      3: begin tgt = 1; acc = (m_st != 1); end
      default: ;
    endcase
    if (acc) begin
      m_st = tgt; m_dw = 0; m_ch = 1;
    end else begin
      m_dw = (m_dw < DMAX) ? m_dw + 1 : DMAX;
      m_ch = 0;
    end
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    chk("state",   b.state,   e.st);
    chk("out",     b.out,     e.o);
    chk("dwell",   b.dwell,   e.dw);
    chk("changed", b.changed, e.ch);
  endtask

  // one clock: drive at the falling edge, predict, compare at the next one
  task automatic cyc(input bit e, input logic [IW-1:0] c);
    b.en = e;
    b.in = c;
    model_step(e, c);
    sbq.push_back('{st: 2'(m_st), o: OW'(code_of(m_st)), dw: DW'(m_dw), ch: m_ch});
    @(negedge clk);
    pop_cmp();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"},   b.state,   32'd1);
    chk({tag, "_out"},     b.out,     32'd2);
    chk({tag, "_dwell"},   b.dwell,   32'd0);
    chk({tag, "_changed"}, b.changed, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    b.en = 1'b0;
    b.in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    model_reset();

    // hold from reset: dwell counts up, then saturates
    repeat (10) cyc(1'b1, 4'h0);
    repeat (12) cyc(1'b1, 4'h0);
    chk("dwell_sat", b.dwell, 32'd15);

    // HOME while Red: no pulse, dwell untouched
    repeat (3) cyc(1'b1, 4'h3);

    // ADVANCE held: Green, Blue, Red
    repeat (7) cyc(1'b1, 4'h1);
    chk("adv_red", b.state, 32'd1);
    chk("adv_pulse", b.changed, 32'd1);

    // gate rejection at dwell 1, acceptance at dwell 3
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h2);
    chk("gate_rej", b.state, 32'd1);
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h2);
    chk("gate_acc_out", b.out, 32'd1);

    // Blue -> Green, then HOME at dwell 0, then HOME held in Red
    repeat (2) cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h2);
    chk("rev_green", b.state, 32'd2);
    cyc(1'b1, 4'h3);
    chk("home_pulse", b.changed, 32'd1);
    repeat (4) cyc(1'b1, 4'h3);
    chk("home_dwell", b.dwell, 32'd4);

    // enable low right after a transition
    repeat (2) cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h1);
    repeat (5) cyc(1'b0, 4'h1);
    chk("frozen_state", b.state, 32'd2);

    // illegal upper bits read as HOLD
    repeat (2) cyc(1'b1, 4'h5);
    cyc(1'b1, 4'h6);
    cyc(1'b1, 4'hB);
    chk("illegal_hold", b.state, 32'd2);

    // into Blue, then async reset mid-cycle
    cyc(1'b1, 4'h1);
    chk("pre_rst_out", b.out, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("async");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sbq.delete();

    // mixed traffic, including illegal codes and enable drops
    for (int i = 0; i < 300; i++) begin
      logic [IW-1:0] c;
      c = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, 15)) : IW'($urandom_range(0, 3));
      cyc($urandom_range(0, 7) != 0, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
